// File: rtl/lm32_x_result_stage_pkg.sv
// Shared encodings for the LM32 X-stage result select and its multi-cycle sequencer.
// Imported by the result mux and the X->M stage top.
package lm32_x_result_stage_pkg;

    localparam int LM32_X_RESULT_SEL_RNG = 2;

    typedef enum logic [1:0] {
        X_SEL_ADD   = 2'd0,
        X_SEL_LOGIC = 2'd1,
        X_SEL_SHIFT = 2'd2,
        X_SEL_MC    = 2'd3
    } x_result_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_MC_HOLD = 2'd2
    } x_state_t;

    // r0 is hardwired to zero, so a write to it is dropped at the tag.
    function automatic logic qualify_write_enable(input logic we, input logic idx_nonzero);
        return we & idx_nonzero;
    endfunction

endpackage

// File: rtl/lm32_x_result_mux.sv
// Pure 4:1 selector choosing the X-stage result by functional unit.
module lm32_x_result_mux
    import lm32_x_result_stage_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [LM32_X_RESULT_SEL_RNG-1:0] sel,
    input  logic [WORD_WIDTH-1:0]            adder_in,
    input  logic [WORD_WIDTH-1:0]            logic_in,
    input  logic [WORD_WIDTH-1:0]            shifter_in,
    input  logic [WORD_WIDTH-1:0]            mc_in,
    output logic [WORD_WIDTH-1:0]            result
);

    // Result select
    always_comb begin
        result = '0;
        case (x_result_sel_t'(sel))
            X_SEL_ADD:   result = adder_in;
            X_SEL_LOGIC: result = logic_in;
            X_SEL_SHIFT: result = shifter_in;
            X_SEL_MC:    result = mc_in;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/lm32_x_result_stage.sv
// X-stage result select, multi-cycle op sequencer (start/wait/hold/abort/watchdog)
// and the X->M pipeline register with its writeback tag.
module lm32_x_result_stage
    import lm32_x_result_stage_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int MC_MAX_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_x,
    input  logic                            kill_x,
    input  logic                            stall_m,
    input  logic [LM32_X_RESULT_SEL_RNG-1:0] x_result_sel,
    input  logic [WORD_WIDTH-1:0]           adder_result_x,
    input  logic [WORD_WIDTH-1:0]           logic_result_x,
    input  logic [WORD_WIDTH-1:0]           shifter_result_x,
    input  logic [WORD_WIDTH-1:0]           mc_result_x,
    input  logic                            mc_done,
    input  logic                            write_enable_x,
    input  logic [REG_IDX_WIDTH-1:0]        write_idx_x,
    output logic                            mc_start,
    output logic                            mc_abort,
    output logic                            stall_request_x,
    output logic                            mc_timeout,
    output logic [WORD_WIDTH-1:0]           operand_m,
    output logic                            valid_m,
    output logic                            write_enable_m,
    output logic [REG_IDX_WIDTH-1:0]        write_idx_m
);

    localparam int WD_W = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_CYCLES - 1);

    x_state_t                  state_r, state_s;
    logic [WD_W-1:0]           wd_r, wd_s;
    logic                      timeout_r, timeout_set_s;
    logic [WORD_WIDTH-1:0]     hold_result_r;
    logic                      hold_we_r;
    logic [REG_IDX_WIDTH-1:0]  hold_idx_r;
    logic                      hold_load_s;
    logic [WORD_WIDTH-1:0]     operand_m_r, m_operand_s;
    logic                      valid_m_r, m_valid_s;
    logic                      we_m_r, m_we_s;
    logic [REG_IDX_WIDTH-1:0]  idx_m_r, m_idx_s;
    logic                      m_load_s;
    logic                      start_s, abort_s;
    logic                      stall_request_s, accept_s, launch_s, we_tag_s;
    logic [WORD_WIDTH-1:0]     mux_result_s;

    lm32_x_result_mux #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_mux (
        .sel        (x_result_sel),
        .adder_in   (adder_result_x),
        .logic_in   (logic_result_x),
        .shifter_in (shifter_result_x),
        .mc_in      (mc_result_x),
        .result     (mux_result_s)
    );

    // Stall depends only on state so mc_done can never feed back into the stall path.
    assign stall_request_s = (state_r != ST_IDLE);
    assign accept_s        = valid_x & ~kill_x & ~stall_m & ~stall_request_s;
    assign launch_s        = valid_x & ~kill_x & (x_result_sel == X_SEL_MC);
    assign we_tag_s        = qualify_write_enable(write_enable_x, |write_idx_x);

    // Next-state, watchdog and M-register load decisions
    always_comb begin
        state_s       = state_r;
        wd_s          = wd_r;
        start_s       = 1'b0;
        abort_s       = 1'b0;
        timeout_set_s = 1'b0;
        hold_load_s   = 1'b0;
        m_load_s      = ~stall_m;
        m_operand_s   = operand_m_r;
        m_valid_s     = 1'b0;
        m_we_s        = 1'b0;
        m_idx_s       = idx_m_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    start_s = 1'b1;
                    wd_s    = '0;
                    state_s = ST_MC_WAIT;
                end else if (accept_s) begin
                    m_operand_s = mux_result_s;
                    m_valid_s   = 1'b1;
                    m_we_s      = we_tag_s;
                    m_idx_s     = write_idx_x;
                end else begin
                    m_valid_s = 1'b0;
                end
            end
            ST_MC_WAIT: begin
                if (kill_x) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (mc_done) begin
                    if (stall_m) begin
                        hold_load_s = 1'b1;
                        state_s     = ST_MC_HOLD;
                    end else begin
                        m_operand_s = mc_result_x;
                        m_valid_s   = 1'b1;
                        m_we_s      = we_tag_s;
                        m_idx_s     = write_idx_x;
                        state_s     = ST_IDLE;
                    end
                end else if (wd_r == WD_LAST) begin
                    timeout_set_s = 1'b1;
                    abort_s       = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    wd_s = wd_r + WD_W'(1);
                end
            end
            ST_MC_HOLD: begin
                if (kill_x) begin
                    state_s = ST_IDLE;
                end else if (!stall_m) begin
                    m_operand_s = hold_result_r;
                    m_valid_s   = 1'b1;
                    m_we_s      = hold_we_r;
                    m_idx_s     = hold_idx_r;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_MC_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, watchdog, hold register and X->M pipeline register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            wd_r          <= '0;
            timeout_r     <= 1'b0;
            hold_result_r <= '0;
            hold_we_r     <= 1'b0;
            hold_idx_r    <= '0;
            operand_m_r   <= '0;
            valid_m_r     <= 1'b0;
            we_m_r        <= 1'b0;
            idx_m_r       <= '0;
        end else begin
            state_r <= state_s;
            wd_r    <= wd_s;
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end
            if (hold_load_s) begin
                hold_result_r <= mc_result_x;
                hold_we_r     <= we_tag_s;
                hold_idx_r    <= write_idx_x;
            end
            if (m_load_s) begin
                operand_m_r <= m_operand_s;
                valid_m_r   <= m_valid_s;
                we_m_r      <= m_we_s;
                idx_m_r     <= m_idx_s;
            end
        end
    end

    // The unit handshake pulses are same-cycle, so reset must mask them directly.
    assign mc_start        = start_s & ~rst_i;
    assign mc_abort        = abort_s & ~rst_i;
    assign stall_request_x = stall_request_s;
    assign mc_timeout      = timeout_r;
    assign operand_m       = operand_m_r;
    assign valid_m         = valid_m_r;
    assign write_enable_m  = we_m_r;
    assign write_idx_m     = idx_m_r;

endmodule

// File: tb/tb_lm32_x_result_stage.sv
// Self-checking bench for lm32_x_result_stage: directed scenarios plus randomized
// single-cycle and multi-cycle traffic checked against a transaction-level model.
module tb_lm32_x_result_stage;

    logic        clk = 1'b0;
    logic        rst_i, valid_x, kill_x, stall_m, mc_done, write_enable_x;
    logic [1:0]  x_result_sel;
    logic [31:0] adder_result_x, logic_result_x, shifter_result_x, mc_result_x;
    logic [4:0]  write_idx_x;
    logic        mc_start, mc_abort, stall_request_x, mc_timeout, valid_m, write_enable_m;
    logic [31:0] operand_m;
    logic [4:0]  write_idx_m;

    int checks = 0;
    int errors = 0;

    lm32_x_result_stage dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .valid_x          (valid_x),
        .kill_x           (kill_x),
        .stall_m          (stall_m),
        .x_result_sel     (x_result_sel),
        .adder_result_x   (adder_result_x),
        .logic_result_x   (logic_result_x),
        .shifter_result_x (shifter_result_x),
        .mc_result_x      (mc_result_x),
        .mc_done          (mc_done),
        .write_enable_x   (write_enable_x),
        .write_idx_x      (write_idx_x),
        .mc_start         (mc_start),
        .mc_abort         (mc_abort),
        .stall_request_x  (stall_request_x),
        .mc_timeout       (mc_timeout),
        .operand_m        (operand_m),
        .valid_m          (valid_m),
        .write_enable_m   (write_enable_m),
        .write_idx_m      (write_idx_m)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        valid_x = 1'b0; kill_x = 1'b0; stall_m = 1'b0; mc_done = 1'b0;
        x_result_sel = 2'd0; write_enable_x = 1'b0; write_idx_x = 5'd0;
        adder_result_x = $urandom; logic_result_x = $urandom;
        shifter_result_x = $urandom; mc_result_x = $urandom;
    endtask

    task automatic launch_mc(input logic st, input logic [4:0] idx);
        valid_x = 1'b1; kill_x = 1'b0; stall_m = st; x_result_sel = 2'd3;
        write_enable_x = 1'b1; write_idx_x = idx; mc_done = 1'b0;
        #1;
        checks++;
        if (mc_start !== 1'b1) begin
            errors++; $display("FAIL launch_start: mc_start=%b expected 1", mc_start);
        end
        tick();
    endtask

    task automatic test_reset();
        logic [42:0] outs;
        quiet_inputs();
        rst_i = 1'b1; valid_x = 1'b1; x_result_sel = 2'd3; mc_done = 1'b1;
        tick(); tick();
        outs = {mc_start, mc_abort, stall_request_x, mc_timeout, valid_m, write_enable_m,
                write_idx_m, operand_m};
        checks++;
        if (outs !== 43'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_i = 1'b0;
        quiet_inputs();
        tick();
    endtask

    task automatic test_logic();
        x_result_sel = 2'd1; logic_result_x = 32'h0000F0F0; write_idx_x = 5'd3;
        write_enable_x = 1'b1; valid_x = 1'b1;
        tick();
        checks++;
        if ({valid_m, write_enable_m, write_idx_m, operand_m} !== {1'b1, 1'b1, 5'd3, 32'h0000F0F0}) begin
            errors++; $display("FAIL logic_sel: got v=%b we=%b idx=%0d op=%h expected 1 1 3 0000f0f0",
                                valid_m, write_enable_m, write_idx_m, operand_m);
        end
        quiet_inputs();
    endtask

    task automatic test_add_idx0();
        logic [31:0] a;
        a = $urandom;
        x_result_sel = 2'd0; adder_result_x = a; write_idx_x = 5'd0;
        write_enable_x = 1'b1; valid_x = 1'b1;
        tick();
        checks++;
        if ({valid_m, write_enable_m, operand_m} !== {1'b1, 1'b0, a}) begin
            errors++; $display("FAIL add_idx0: got v=%b we=%b op=%h expected 1 0 %h",
                                valid_m, write_enable_m, operand_m, a);
        end
        quiet_inputs();
    endtask

    task automatic test_random_alu(input int n);
        logic known, ev, ewe;
        logic [4:0] eidx;
        logic [31:0] eop;
        known = 1'b0; ev = 1'b0; ewe = 1'b0; eidx = 5'd0; eop = 32'd0;
        for (int i = 0; i < n; i++) begin
            valid_x = ($urandom_range(0, 3) != 0);
            kill_x = ($urandom_range(0, 4) == 0);
            stall_m = ($urandom_range(0, 3) == 0);
            x_result_sel = 2'($urandom_range(0, 3));
            if (x_result_sel == 2'd3 && valid_x && !kill_x) kill_x = 1'b1;
            adder_result_x = $urandom; logic_result_x = $urandom;
            shifter_result_x = $urandom; mc_result_x = $urandom;
            write_enable_x = 1'($urandom_range(0, 1));
            write_idx_x = 5'($urandom_range(0, 31));
            mc_done = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({mc_start, mc_abort} !== 2'b00) begin
                errors++; $display("FAIL alu_no_mc: start=%b abort=%b expected 0 0", mc_start, mc_abort);
            end
            if (!stall_m) begin
                known = 1'b1;
                if (valid_x && !kill_x) begin
                    ev = 1'b1; ewe = write_enable_x && (write_idx_x != 5'd0); eidx = write_idx_x;
                    eop = (x_result_sel == 2'd0) ? adder_result_x :
                          (x_result_sel == 2'd1) ? logic_result_x : shifter_result_x;
                end else begin
                    ev = 1'b0; ewe = 1'b0;
                end
            end
            tick();
            checks++;
            if (stall_request_x !== 1'b0) begin
                errors++; $display("FAIL alu_stall_req: got %b expected 0", stall_request_x);
            end
            if (known) begin
                checks++;
                if ({valid_m, write_enable_m} !== {ev, ewe}) begin
                    errors++; $display("FAIL alu_tag: got v=%b we=%b expected %b %b",
                                        valid_m, write_enable_m, ev, ewe);
                end
                if (ev) begin
                    checks++;
                    if ({write_idx_m, operand_m} !== {eidx, eop}) begin
                        errors++; $display("FAIL alu_data: got idx=%0d op=%h expected %0d %h",
                                            write_idx_m, operand_m, eidx, eop);
                    end
                end
            end
        end
        quiet_inputs();
    endtask

    task automatic test_mc_basic();
        int stalls, starts;
        stalls = 0; starts = 1;
        launch_mc(1'b0, 5'd7);
        for (int c = 1; c <= 5; c++) begin
            mc_done = (c == 5);
            mc_result_x = (c == 5) ? 32'h12345678 : $urandom;
            #1;
            if (stall_request_x) stalls++;
            if (mc_start) starts++;
            tick();
        end
        quiet_inputs();
        checks++;
        if (stalls != 5 || starts != 1) begin
            errors++; $display("FAIL mc_basic_counts: stalls=%0d starts=%0d expected 5 1", stalls, starts);
        end
        checks++;
        if ({stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m} !==
            {1'b0, 1'b1, 1'b1, 5'd7, 32'h12345678}) begin
            errors++; $display("FAIL mc_basic_result: sr=%b v=%b we=%b idx=%0d op=%h expected 0 1 1 7 12345678",
                                stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m);
        end
    endtask

    task automatic test_mc_hold();
        logic [31:0] r;
        r = $urandom;
        x_result_sel = 2'd1; logic_result_x = 32'hCAFE0001; write_idx_x = 5'd4;
        write_enable_x = 1'b1; valid_x = 1'b1;
        tick();
        launch_mc(1'b1, 5'd9);
        for (int c = 1; c <= 6; c++) begin
            stall_m = (c < 6);
            mc_done = (c == 3);
            mc_result_x = (c == 3) ? r : ~r;
            tick();
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m} !==
                    {1'b1, 1'b1, 1'b1, 5'd4, 32'hCAFE0001}) begin
                    errors++; $display("FAIL mc_hold_frozen c=%0d: sr=%b v=%b idx=%0d op=%h expected 1 1 4 cafe0001",
                                        c, stall_request_x, valid_m, write_idx_m, operand_m);
                end
            end
        end
        checks++;
        if ({stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m} !==
            {1'b0, 1'b1, 1'b1, 5'd9, r}) begin
            errors++; $display("FAIL mc_hold_release: sr=%b v=%b we=%b idx=%0d op=%h expected 0 1 1 9 %h",
                                stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m, r);
        end
        quiet_inputs();
    endtask

    task automatic test_mc_kill();
        launch_mc(1'b0, 5'd12);
        tick();
        mc_done = 1'b1; kill_x = 1'b1; mc_result_x = $urandom;
        #1;
        checks++;
        if (mc_abort !== 1'b1) begin
            errors++; $display("FAIL mc_kill_abort: got %b expected 1", mc_abort);
        end
        tick();
        quiet_inputs();
        #1;
        checks++;
        if ({stall_request_x, valid_m, write_enable_m, mc_abort} !== 4'b0000) begin
            errors++; $display("FAIL mc_kill_after: sr=%b v=%b we=%b abort=%b expected 0 0 0 0",
                                stall_request_x, valid_m, write_enable_m, mc_abort);
        end
    endtask

    task automatic test_back_to_back(input int n);
        int l, h, stalls, starts, aborts, exp_stalls;
        logic st;
        logic [4:0] idx;
        logic [31:0] r;
        for (int k = 0; k < n; k++) begin
            l = $urandom_range(1, 12); h = $urandom_range(1, 4); st = 1'($urandom_range(0, 1));
            idx = 5'($urandom_range(0, 31)); r = $urandom;
            stalls = 0; starts = 0; aborts = 0;
            launch_mc(1'b0, idx);
            for (int c = 1; c <= l; c++) begin
                stall_m = (c == l) ? st : 1'($urandom_range(0, 1));
                mc_done = (c == l);
                mc_result_x = (c == l) ? r : $urandom;
                #1;
                if (stall_request_x) stalls++;
                if (mc_start) starts++;
                if (mc_abort) aborts++;
                tick();
            end
            mc_done = 1'b0; mc_result_x = $urandom;
            if (st) begin
                for (int j = 1; j <= h; j++) begin
                    stall_m = (j < h);
                    #1;
                    if (stall_request_x) stalls++;
                    if (mc_abort) aborts++;
                    tick();
                end
            end
            exp_stalls = l + (st ? h : 0);
            checks++;
            if (stalls != exp_stalls || starts != 0 || aborts != 0) begin
                errors++; $display("FAIL b2b_counts k=%0d: stalls=%0d starts=%0d aborts=%0d expected %0d 0 0",
                                    k, stalls, starts, aborts, exp_stalls);
            end
            checks++;
            if ({stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m} !==
                {1'b0, 1'b1, (idx != 5'd0), idx, r}) begin
                errors++; $display("FAIL b2b_result k=%0d: sr=%b v=%b we=%b idx=%0d op=%h expected idx=%0d op=%h",
                                    k, stall_request_x, valid_m, write_enable_m, write_idx_m, operand_m, idx, r);
            end
        end
        quiet_inputs();
    endtask

    task automatic test_timeout_and_reset();
        int aborts, abort_cycle;
        logic [42:0] outs;
        aborts = 0; abort_cycle = 0;
        launch_mc(1'b0, 5'd5);
        for (int c = 1; c <= 64; c++) begin
            stall_m = 1'b0; mc_done = 1'b0;
            #1;
            if (mc_abort) begin aborts++; abort_cycle = c; end
            tick();
        end
        quiet_inputs();
        checks++;
        if (aborts != 1 || abort_cycle != 64) begin
            errors++; $display("FAIL timeout_abort: count=%0d at=%0d expected 1 at 64", aborts, abort_cycle);
        end
        checks++;
        if ({mc_timeout, stall_request_x, valid_m} !== 3'b100) begin
            errors++; $display("FAIL timeout_state: to=%b sr=%b v=%b expected 1 0 0",
                                mc_timeout, stall_request_x, valid_m);
        end
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        checks++;
        if ({mc_timeout, stall_request_x, valid_m} !== 3'b100) begin
            errors++; $display("FAIL stray_done: to=%b sr=%b v=%b expected 1 0 0",
                                mc_timeout, stall_request_x, valid_m);
        end
        launch_mc(1'b0, 5'd6);
        tick(); tick();
        rst_i = 1'b1; valid_x = 1'b1; kill_x = 1'b1; mc_done = 1'b1;
        #1;
        checks++;
        if ({mc_start, mc_abort} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses: start=%b abort=%b expected 0 0", mc_start, mc_abort);
        end
        tick();
        outs = {mc_start, mc_abort, stall_request_x, mc_timeout, valid_m, write_enable_m,
                write_idx_m, operand_m};
        checks++;
        if (outs !== 43'd0) begin
            errors++; $display("FAIL reset_mid_wait: got %h expected 0", outs);
        end
        rst_i = 1'b0;
        quiet_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add_idx0();
        test_random_alu(300);
        test_mc_basic();
        test_mc_hold();
        test_mc_kill();
        test_back_to_back(25);
        test_timeout_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
